mem_req_unit: RTL

Memory-access issue unit for the EXE/MEM boundary that replaces the single-outstanding data-SRAM request logic. It performs the following steps:
- Accepts one load/store per handshake.
- Checks alignment and raises an exception instead of issuing a misaligned access.
- Builds size, strobe and aligned write data, and issues on the SRAM-like req/addr_ok/data_ok bus.
- Tracks up to DEPTH outstanding requests in order.
- Returns extended or merged load results to the MEM stage.

On flush, all in-flight requests are marked dead and their responses are discarded.

---
 rtl/mem_req_unit.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/mem_req_unit.sv
// mem_req_unit: in-order load/store issue unit with alignment checks, byte-lane formatting and DEPTH outstanding SRAM-bus requests
module mem_req_unit #(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [31:0]       in_rt,
  input  logic              flush,
  output logic              ex_valid,
  output logic [4:0]        ex_code,
  output logic [ADDR_W-1:0] ex_badvaddr,
  output logic              req,
  output logic              wr,
  output logic [2:0]        size,
  output logic [ADDR_W-1:0] addr,
  output logic [3:0]        wstrb,
  output logic [31:0]       wdata,
  input  logic              addr_ok,
  input  logic              data_ok,
  input  logic [31:0]       rdata,
  output logic              resp_valid,
  output logic              resp_store,
  output logic [31:0]       resp_data,
  output logic              busy
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [3:0] LW = 4'd0, LB = 4'd1, LBU = 4'd2, LH = 4'd3, LHU = 4'd4, LWL = 4'd5, LWR = 4'd6;
  localparam logic [3:0] SW = 4'd8, SB = 4'd9, SH = 4'd10, SWL = 4'd11, SWR = 4'd12;
  logic              hold_v;
  logic [3:0]        hold_op, hold_strb;
  logic [1:0]        hold_low;
  logic [ADDR_W-1:0] hold_addr;
  logic [31:0]       hold_rt, hold_wdata;
  logic [2:0]        hold_size;
  logic [3:0]        f_op [DEPTH];
  logic [1:0]        f_low [DEPTH];
  logic [31:0]       f_rt [DEPTH];
  logic [DEPTH-1:0]  f_dead;
  logic [PW-1:0]     wp, rp;
  logic [CW-1:0]     cnt;
  logic [1:0]        lo, h_low;
  logic              mis, accept, push, pop, is_l, is_r;
  logic [2:0]        n_size;
  logic [3:0]        n_strb, h_op;
  logic [31:0]       n_wdata, h_rt, sh;
  logic [ADDR_W-1:0] n_addr;
  assign lo     = in_addr[1:0];
  assign is_l   = in_op == LWL || in_op == SWL;
  assign is_r   = in_op == LWR || in_op == SWR;
  assign mis    = ((in_op == LW || in_op == SW) && lo != 2'b00) ||
                  ((in_op == LH || in_op == LHU || in_op == SH) && lo[0]);
  assign req      = hold_v & (cnt < FULL) & ~flush;
  assign in_ready = (~hold_v | (req & addr_ok)) & ~flush;
  assign accept   = in_valid & in_ready;
  assign push     = req & addr_ok;
  assign pop      = data_ok & (cnt != '0);
  assign ex_valid    = accept & mis;
  assign ex_code     = in_op[3] ? 5'h05 : 5'h04;
  assign ex_badvaddr = in_addr;
  assign wr    = hold_op[3];
  assign size  = hold_size;
  assign addr  = hold_addr;
  assign wstrb = hold_strb;
  assign wdata = hold_wdata;
  assign busy  = hold_v | (cnt != '0);
  // Bus fields are formatted at accept time so the issue cycle only drives flops.
  always_comb begin
    n_addr  = is_l ? {in_addr[ADDR_W-1:2], 2'b00} : in_addr;
    n_size  = is_l ? (lo[1] ? 3'd2 : {2'b00, lo[0]}) :
              is_r ? (lo[1] ? {2'b00, ~lo[0]} : 3'd2) :
              (in_op == LW || in_op == SW) ? 3'd2 :
              (in_op == LH || in_op == LHU || in_op == SH) ? 3'd1 : 3'd0;
    n_strb  = in_op == SB  ? 4'b0001 << lo :
              in_op == SH  ? (lo[1] ? 4'b1100 : 4'b0011) :
              in_op == SW  ? 4'b1111 :
              in_op == SWL ? 4'b1111 >> ~lo :
              in_op == SWR ? 4'b1111 << lo : 4'b0000;
    n_wdata = in_op == SB  ? {4{in_rt[7:0]}} :
              in_op == SH  ? {2{in_rt[15:0]}} :
              in_op == SWL ? in_rt >> {~lo, 3'b000} :
              in_op == SWR ? in_rt << {lo, 3'b000} : in_rt;
  end
  always_comb begin
    h_op       = f_op[rp];
    h_low      = f_low[rp];
    h_rt       = f_rt[rp];
    sh         = rdata >> {h_low, 3'b000};
    resp_valid = pop & ~f_dead[rp];
    resp_store = h_op[3];
    resp_data  = h_op[3]     ? 32'h0 :
                 h_op == LB  ? {{24{sh[7]}}, sh[7:0]} :
                 h_op == LBU ? {24'h0, sh[7:0]} :
                 h_op == LH  ? {{16{sh[15]}}, sh[15:0]} :
                 h_op == LHU ? {16'h0, sh[15:0]} :
                 h_op == LWL ? (rdata << {~h_low, 3'b000}) | (h_rt & ~(32'hFFFF_FFFF << {~h_low, 3'b000})) :
                 h_op == LWR ? sh | (h_rt & ~(32'hFFFF_FFFF >> {h_low, 3'b000})) : rdata;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_v     <= 1'b0;
      hold_op    <= '0;
      hold_low   <= '0;
      hold_addr  <= '0;
      hold_rt    <= '0;
      hold_size  <= '0;
      hold_strb  <= '0;
      hold_wdata <= '0;
      wp         <= '0;
      rp         <= '0;
      cnt        <= '0;
      f_dead     <= '0;
    end else begin
      if (flush) hold_v <= 1'b0;
      else if (accept & ~mis) begin
        hold_v     <= 1'b1;
        hold_op    <= in_op;
        hold_low   <= lo;
        hold_addr  <= n_addr;
        hold_rt    <= in_rt;
        hold_size  <= n_size;
        hold_strb  <= n_strb;
        hold_wdata <= n_wdata;
      end else if (push) hold_v <= 1'b0;
      f_dead <= f_dead | {DEPTH{flush}};
      if (push) begin
        f_op[wp]   <= hold_op;
        f_low[wp]  <= hold_low;
        f_rt[wp]   <= hold_rt;
        f_dead[wp] <= flush;
        wp         <= wp == PW'(DEPTH - 1) ? '0 : wp + 1'b1;
      end
      if (pop) rp <= rp == PW'(DEPTH - 1) ? '0 : rp + 1'b1;
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end
endmodule
